bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 175 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start/done handshake launches one conversion at a time. A result takes WIDTH
// cycles, and back-to-back conversions complete one every WIDTH+1 cycles.
// Optional feature macro: BIN2BCD_SIGNED_EN. When it is defined, bin is treated as
// two's complement: the magnitude is converted and its sign is reported on neg.
// When the macro is undefined, bin is unsigned and neg is tied low.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [BW-1:0]    dig_q;
  logic             ovf_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_out_q;

  logic [BW-1:0]    adj_d;
  logic [BW-1:0]    dig_d;
  logic [WIDTH-1:0] sr_d;
  logic             ovf_d;
  logic [WIDTH-1:0] load_mag_d;
  logic             load_sign_d;

  // Add 3 to every digit that is 5 or more. A valid digit (0..9) stays within 4 bits.
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] digs);
    logic [BW-1:0] res;
    logic [3:0]    d;
    res = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = digs[4*k +: 4];
      res[4*k +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
    end
    return res;
  endfunction

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude of a two's-complement operand. The most negative value maps to
  // 2^(WIDTH-1), which is still representable as a WIDTH-bit unsigned value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic sign_q;
  logic neg_q;
`endif

  // Operand preparation at acceptance: magnitude and sign (unsigned build passes bin through).
  always_comb begin
`ifdef BIN2BCD_SIGNED_EN
    load_mag_d  = magnitude(bin);
    load_sign_d = bin[WIDTH-1];
`else
    load_mag_d  = bin;
    load_sign_d = 1'b0;
`endif
  end

  // One double-dabble step: adjust digits, shift {digits, sr} left, and catch the digit carry-out.
  always_comb begin
    adj_d = add3_all(dig_q);
    dig_d = {adj_d[BW-2:0], sr_q[WIDTH-1]};
    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
    ovf_d = ovf_q | adj_d[BW-1];
  end

  // Control FSM with registered handshake outputs and the conversion datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      sr_q      <= '0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q    <= load_mag_d;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            state_q <= S_SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          dig_q <= dig_d;
          sr_q  <= sr_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CW'(1);
          // The final step publishes the result in the same edge.
          if (cnt_q == CW'(1)) begin
            bcd_q     <= dig_d;
            ovf_out_q <= ovf_d;
            state_q   <= S_DONE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  // The sign is latched with the operand and published with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if ((state_q != S_SHIFT) && start) begin
        sign_q <= load_sign_d;
      end
      if ((state_q == S_SHIFT) && (cnt_q == CW'(1))) begin
        neg_q <= sign_q;
      end
    end
  end

  assign neg = neg_q;
`else
  assign neg = load_sign_d;
`endif

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq. Four instances cover the configurations:
// W32/D10, W8/D3, W8/D2 and W16/D5.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  logic rst_d_n;

  logic        start_a, rdy_a, busy_a, done_a, ovf_a, neg_a;
  logic [31:0] bin_a;
  logic [39:0] bcd_a;

  logic        start_b, rdy_b, busy_b, done_b, ovf_b, neg_b;
  logic [7:0]  bin_b;
  logic [11:0] bcd_b;

  logic        start_c, rdy_c, busy_c, done_c, ovf_c, neg_c;
  logic [7:0]  bin_c;
  logic [7:0]  bcd_c;

  logic        start_d, rdy_d, busy_d, done_d, ovf_d, neg_d;
  logic [15:0] bin_d;
  logic [19:0] bcd_d;

  logic [3:0]  done_v;
  int n_cmp;
  int n_err;
  int cyc;
  int cnt;

  assign done_v = {done_d, done_c, done_b, done_a};

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a), .ready(rdy_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .neg(neg_a));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b), .ready(rdy_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .neg(neg_b));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c), .ready(rdy_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .neg(neg_c));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_d (
    .clk(clk), .rst_n(rst_d_n), .start(start_d), .bin(bin_d), .ready(rdy_d),
    .busy(busy_d), .done(done_d), .bcd(bcd_d), .overflow(ovf_d), .neg(neg_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: raise start for one edge, return one falling edge after acceptance.
  task automatic go(input int idx, input logic [31:0] val);
    case (idx)
      0: begin start_a = 1'b1; bin_a = val; end
      1: begin start_b = 1'b1; bin_b = val[7:0]; end
      2: begin start_c = 1'b1; bin_c = val[7:0]; end
      default: begin start_d = 1'b1; bin_d = val[15:0]; end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
  endtask

  // Count falling edges until done is seen; an expired budget counts as a mismatch.
  task automatic wait_done(input int idx, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done_v[idx] && cycles < budget);
    if (!done_v[idx]) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout dut%0d: no done within %0d cycles", idx, budget);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; rst_d_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0; bin_d = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(rdy_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_bcd", 64'(bcd_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    check("rst_neg", 64'(neg_a), 64'd0);
    rst_n = 1'b1; rst_d_n = 1'b1;
    @(negedge clk);

`ifndef BIN2BCD_SIGNED_EN
    // W32: zero, with the done pulse in the 33rd cycle after the accepting edge.
    go(0, 32'd0);
    check("a_busy", 64'(busy_a), 64'd1);
    check("a_ready_busy", 64'(rdy_a), 64'd0);
    wait_done(0, 60, cyc);
    check("a_latency", 64'(cyc + 1), 64'd33);
    check("a_zero_bcd", 64'(bcd_a), 64'd0);
    check("a_zero_ovf", 64'(ovf_a), 64'd0);
    @(negedge clk);
    check("a_done_pulse", 64'(done_a), 64'd0);
    check("a_ready_idle", 64'(rdy_a), 64'd1);
    go(0, 32'hFFFF_FFFF);
    wait_done(0, 60, cyc);
    check("a_max_bcd", 64'(bcd_a), 64'h42_9496_7295);
    check("a_max_ovf", 64'(ovf_a), 64'd0);

    // W8/D3: 255, then back-to-back 9 started during the DONE cycle.
    go(1, 32'd255);
    wait_done(1, 30, cyc);
    check("b_latency", 64'(cyc + 1), 64'd9);
    check("b_255", 64'(bcd_b), 64'h255);
    go(1, 32'd9);
    check("b_hold", 64'(bcd_b), 64'h255);
    wait_done(1, 30, cyc);
    check("b_b2b_gap", 64'(cyc + 1), 64'd9);
    check("b_9", 64'(bcd_b), 64'h009);

    // W8/D2: overflow keeps the low digits; the next result clears it.
    go(2, 32'd255);
    wait_done(2, 30, cyc);
    check("c_ovf", 64'(ovf_c), 64'd1);
    check("c_low", 64'(bcd_c), 64'h55);
    @(negedge clk);
    check("c_ovf_hold", 64'(ovf_c), 64'd1);
    go(2, 32'd99);
    wait_done(2, 30, cyc);
    check("c_ovf_clr", 64'(ovf_c), 64'd0);
    check("c_99", 64'(bcd_c), 64'h99);
`else
    // Signed W8/D3 vectors.
    go(1, 32'h0000_00FF);
    wait_done(1, 30, cyc);
    check("s_m1_neg", 64'(neg_b), 64'd1);
    check("s_m1_bcd", 64'(bcd_b), 64'h001);
    go(1, 32'h0000_0080);
    wait_done(1, 30, cyc);
    check("s_m128_neg", 64'(neg_b), 64'd1);
    check("s_m128_bcd", 64'(bcd_b), 64'h128);
    go(1, 32'h0000_007F);
    wait_done(1, 30, cyc);
    check("s_127_neg", 64'(neg_b), 64'd0);
    check("s_127_bcd", 64'(bcd_b), 64'h127);
`endif

    // W16: a start while busy is ignored; exactly one done for 1234.
    go(3, 32'd1234);
    repeat (2) @(negedge clk);
    start_d = 1'b1; bin_d = 16'd9999;
    @(negedge clk);
    start_d = 1'b0;
    wait_done(3, 40, cyc);
    check("d_bcd", 64'(bcd_d), 64'h01234);
    check("d_neg", 64'(neg_d), 64'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_d) cnt++;
    end
    check("d_single_done", 64'(cnt), 64'd0);
    check("d_bcd_stable", 64'(bcd_d), 64'h01234);

    // W16: reset mid-conversion aborts at once with no done.
    go(3, 32'd500);
    repeat (4) @(negedge clk);
    check("d_busy_mid", 64'(busy_d), 64'd1);
    rst_d_n = 1'b0;
    #1;
    check("d_ar_ready", 64'(rdy_d), 64'd1);
    check("d_ar_busy", 64'(busy_d), 64'd0);
    check("d_ar_bcd", 64'(bcd_d), 64'd0);
    check("d_ar_ovf", 64'(ovf_d), 64'd0);
    @(negedge clk);
    rst_d_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_d) cnt++;
    end
    check("d_no_done", 64'(cnt), 64'd0);
    check("d_idle_ready", 64'(rdy_d), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
